// File: rtl/rtc_bus_responder_if.sv
// Strobe bus between an RTC initiator (address/RD/WR sequencer) and the RTC device.
// The initiator drives the strobes and ad_in; the device returns ad_out with its drive enable.
interface rtc_bus_responder_if;
    logic       cs;
    logic       ad_sel;
    logic       wr;
    logic       rd;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        output cs, ad_sel, wr, rd, ad_in,
        input  ad_out, ad_oe
    );

    modport slave (
        input  cs, ad_sel, wr, rd, ad_in,
        output ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// Device side of the RTC strobe bus: BCD timekeeping registers advanced once per second,
// with an address phase latch and data-phase register writes and reads.
module rtc_bus_responder #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_responder_if.slave bus,
    output logic               tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    localparam logic [7:0] AddrCtrl  = 8'h00;
    localparam logic [7:0] AddrSec   = 8'h21;
    localparam logic [7:0] AddrMin   = 8'h22;
    localparam logic [7:0] AddrHour  = 8'h23;
    localparam logic [7:0] AddrDate  = 8'h24;
    localparam logic [7:0] AddrMonth = 8'h25;
    localparam logic [7:0] AddrYear  = 8'h26;

    typedef enum logic [1:0] {
        StIdle,
        StAddrWr,
        StDataWr,
        StDataRd
    } state_e;

    // Units digit 9 (or above) rolls to 0 and carries into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] units;
        logic [3:0] tens;
        units = v[3:0];
        tens  = v[7:4];
        if (units >= 4'd9) begin
            units = 4'd0;
            tens  = tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    logic [1:0] cs_sync_q, ad_sel_sync_q, wr_sync_q, rd_sync_q;
    logic       wr_prev_q, rd_prev_q;
    logic       cs_s, ad_sel_s, wr_s, rd_s;
    logic       wr_fall, rd_rise, rd_fall;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] ad_out_q;
    logic       ad_oe_q, ad_oe_d;
    logic       addr_we, data_we, rd_load, time_we;
    logic [7:0] rd_data;

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] date_q, date_d;
    logic [7:0] month_q, month_d;
    logic [7:0] year_q, year_d;
    logic       halt_q, halt_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            tick_q;
    logic            wrap, inc_apply;
    logic [7:0]      year_bin;
    logic            leap;
    logic [7:0]      date_max;

    assign cs_s     = cs_sync_q[1];
    assign ad_sel_s = ad_sel_sync_q[1];
    assign wr_s     = wr_sync_q[1];
    assign rd_s     = rd_sync_q[1];

    assign wr_fall = wr_prev_q & ~wr_s;
    assign rd_rise = rd_s & ~rd_prev_q;
    assign rd_fall = rd_prev_q & ~rd_s;

    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign tick       = tick_q;

    // Bus sequencing; ADDR_WR/DATA_WR last one cycle and accept new strobes like IDLE.
    always_comb begin
        state_d = state_q;
        ad_oe_d = ad_oe_q;
        addr_we = 1'b0;
        data_we = 1'b0;
        rd_load = 1'b0;
        unique case (state_q)
            StIdle, StAddrWr, StDataWr: begin
                state_d = StIdle;
                if (cs_s && wr_fall) begin
                    if (ad_sel_s) begin
                        state_d = StAddrWr;
                        addr_we = 1'b1;
                    end else begin
                        state_d = StDataWr;
                        data_we = 1'b1;
                    end
                end else if (cs_s && !ad_sel_s && rd_rise) begin
                    state_d = StDataRd;
                    rd_load = 1'b1;
                    ad_oe_d = 1'b1;
                end
            end
            StDataRd: begin
                if (rd_fall || !cs_s) begin
                    state_d = StIdle;
                    ad_oe_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            AddrCtrl:  rd_data = {7'b0, halt_q};
            AddrSec:   rd_data = sec_q;
            AddrMin:   rd_data = min_q;
            AddrHour:  rd_data = hour_q;
            AddrDate:  rd_data = date_q;
            AddrMonth: rd_data = month_q;
            AddrYear:  rd_data = year_q;
            default:   rd_data = 8'h00;
        endcase
    end

    assign time_we = data_we && (addr_q >= AddrSec) && (addr_q <= AddrYear);

    assign year_bin = ({4'b0, year_q[7:4]} * 8'd10) + {4'b0, year_q[3:0]};
    assign leap     = (year_bin[1:0] == 2'b00);

    always_comb begin
        date_max = 8'h31;
        case (month_q)
            8'h04, 8'h06, 8'h09, 8'h11: date_max = 8'h30;
            8'h02:                      date_max = leap ? 8'h29 : 8'h28;
            default:                    date_max = 8'h31;
        endcase
    end

    // A write landing on the wrap cycle wins; the increment follows one clk later.
    assign wrap      = !halt_q && (cnt_q == CntMax);
    assign inc_apply = (wrap && !data_we) || pend_q;

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        date_d  = date_q;
        month_d = month_q;
        year_d  = year_q;
        halt_d  = halt_q;
        addr_d  = addr_q;
        pend_d  = wrap && data_we;

        if (time_we || wrap) begin
            cnt_d = '0;
        end else if (!halt_q) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        if (inc_apply) begin
            if (sec_q >= 8'h59) begin
                sec_d = 8'h00;
                if (min_q >= 8'h59) begin
                    min_d = 8'h00;
                    if (hour_q >= 8'h23) begin
                        hour_d = 8'h00;
                        if (date_q >= date_max) begin
                            date_d = 8'h01;
                            if (month_q >= 8'h12) begin
                                month_d = 8'h01;
                                year_d  = (year_q >= 8'h99) ? 8'h00 : bcd_inc(year_q);
                            end else begin
                                month_d = bcd_inc(month_q);
                            end
                        end else begin
                            date_d = bcd_inc(date_q);
                        end
                    end else begin
                        hour_d = bcd_inc(hour_q);
                    end
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end else begin
                sec_d = bcd_inc(sec_q);
            end
        end

        if (addr_we) begin
            addr_d = bus.ad_in;
        end

        if (data_we) begin
            case (addr_q)
                AddrCtrl:  halt_d  = bus.ad_in[0];
                AddrSec:   sec_d   = bus.ad_in;
                AddrMin:   min_d   = bus.ad_in;
                AddrHour:  hour_d  = bus.ad_in;
                AddrDate:  date_d  = bus.ad_in;
                AddrMonth: month_d = bus.ad_in;
                AddrYear:  year_d  = bus.ad_in;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q     <= 2'b00;
            ad_sel_sync_q <= 2'b00;
            wr_sync_q     <= 2'b00;
            rd_sync_q     <= 2'b00;
            wr_prev_q     <= 1'b0;
            rd_prev_q     <= 1'b0;
            state_q       <= StIdle;
            addr_q        <= 8'h00;
            ad_out_q      <= 8'h00;
            ad_oe_q       <= 1'b0;
            sec_q         <= 8'h00;
            min_q         <= 8'h00;
            hour_q        <= 8'h00;
            date_q        <= 8'h01;
            month_q       <= 8'h01;
            year_q        <= 8'h00;
            halt_q        <= 1'b0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cs_sync_q     <= {cs_sync_q[0], bus.cs};
            ad_sel_sync_q <= {ad_sel_sync_q[0], bus.ad_sel};
            wr_sync_q     <= {wr_sync_q[0], bus.wr};
            rd_sync_q     <= {rd_sync_q[0], bus.rd};
            wr_prev_q     <= wr_s;
            rd_prev_q     <= rd_s;
            state_q       <= state_d;
            addr_q        <= addr_d;
            ad_oe_q       <= ad_oe_d;
            if (rd_load) begin
                ad_out_q <= rd_data;
            end
            sec_q         <= sec_d;
            min_q         <= min_d;
            hour_q        <= hour_d;
            date_q        <= date_d;
            month_q       <= month_d;
            year_q        <= year_d;
            halt_q        <= halt_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            tick_q        <= inc_apply;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 4-clk second; inputs change on negedge,
// outputs are sampled on negedge, so every expectation below is counted in whole clk edges.
module tb_rtc_bus_responder;

    localparam int unsigned TickDiv = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick;

    rtc_bus_responder_if bus ();

    rtc_bus_responder #(
        .TICK_DIV(TickDiv)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tick (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tick_seen = 0;

    // Counts the pulse of the preceding cycle, so negedge reads of tick_seen are race-free.
    always @(posedge clk) begin
        if (tick === 1'b1) tick_seen <= tick_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a negedge; the write commits on the 3rd posedge after wr falls.
    task automatic bus_write(input logic sel, input logic [7:0] data);
        bus.cs     = 1'b1;
        bus.ad_sel = sel;
        bus.ad_in  = data;
        bus.wr     = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_reg(input logic [7:0] addr, input logic [7:0] data);
        bus_write(1'b1, addr);
        bus_write(1'b0, data);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        bus_write(1'b1, addr);
        bus.ad_sel = 1'b0;
        bus.rd     = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("oe_before_3clk", {7'b0, bus.ad_oe}, 8'h00);
        @(negedge clk);
        check_eq("oe_at_3clk", {7'b0, bus.ad_oe}, 8'h01);
        data   = bus.ad_out;
        bus.rd = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("oe_hold_after_fall", {7'b0, bus.ad_oe}, 8'h01);
        @(negedge clk);
        check_eq("oe_clear_3clk", {7'b0, bus.ad_oe}, 8'h00);
    endtask

    task automatic set_time(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        set_reg(8'h21, s);
        set_reg(8'h22, m);
        set_reg(8'h23, h);
        set_reg(8'h24, d);
        set_reg(8'h25, mo);
        set_reg(8'h26, y);
    endtask

    // From a halted state with the counter at 0: release HALT, then re-halt before the 2nd wrap.
    task automatic run_one_tick();
        bus_write(1'b1, 8'h00);
        bus_write(1'b0, 8'h00);
        bus_write(1'b0, 8'h01);
    endtask

    task automatic expect_time(input string tag, input logic [7:0] s, input logic [7:0] m,
                               input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                               input logic [7:0] y);
        logic [7:0] v;
        bus_read(8'h21, v); check_eq({tag, "_sec"}, v, s);
        bus_read(8'h22, v); check_eq({tag, "_min"}, v, m);
        bus_read(8'h23, v); check_eq({tag, "_hour"}, v, h);
        bus_read(8'h24, v); check_eq({tag, "_date"}, v, d);
        bus_read(8'h25, v); check_eq({tag, "_month"}, v, mo);
        bus_read(8'h26, v); check_eq({tag, "_year"}, v, y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int t0;

        bus.cs = 1'b0; bus.ad_sel = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.ad_in = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ad_oe", {7'b0, bus.ad_oe}, 8'h00);
        check_eq("rst_ad_out", bus.ad_out, 8'h00);
        check_eq("rst_tick", {7'b0, tick}, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        bus_read(8'h24, v); check_eq("rst_date", v, 8'h01);
        bus_read(8'h25, v); check_eq("rst_month", v, 8'h01);
        bus_read(8'h00, v); check_eq("rst_ctrl", v, 8'h00);
        set_reg(8'h00, 8'h01);

        // Full rollover: exactly one increment and one single-clk pulse.
        set_time(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99);
        t0 = tick_seen;
        run_one_tick();
        repeat (4) @(negedge clk);
        check_eq("roll_tick_count", 8'(tick_seen - t0), 8'd1);
        expect_time("roll", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);

        set_time(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24);
        run_one_tick();
        expect_time("leap24", 8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 8'h24);
        set_time(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h23);
        run_one_tick();
        expect_time("feb23", 8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h23);
        set_time(8'h59, 8'h59, 8'h23, 8'h30, 8'h04, 8'h23);
        run_one_tick();
        expect_time("apr30", 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h23);

        // Collision: unhalt commits at E, ticks at E+4/E+8, SEC write wr_fall lands on E+12 wrap.
        set_reg(8'h21, 8'h05);
        bus_write(1'b1, 8'h00);
        bus_write(1'b0, 8'h00);
        bus_write(1'b1, 8'h21);
        bus.ad_sel = 1'b0; bus.ad_in = 8'h10; bus.wr = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("coll_tick_write_cycle", {7'b0, tick}, 8'h00);
        bus.rd = 1'b1;
        @(negedge clk);
        check_eq("coll_tick_deferred", {7'b0, tick}, 8'h01);
        @(negedge clk);
        check_eq("coll_tick_after", {7'b0, tick}, 8'h00);
        @(negedge clk);
        check_eq("coll_rd_oe", {7'b0, bus.ad_oe}, 8'h01);
        check_eq("coll_sec", bus.ad_out, 8'h11);
        bus.rd = 1'b0;
        repeat (3) @(negedge clk);
        set_reg(8'h00, 8'h01);

        // HALT holds everything; after release, 41 clk contain 10 pulses and the re-halt adds one.
        set_reg(8'h21, 8'h30);
        bus_write(1'b1, 8'h00);
        t0 = tick_seen;
        repeat (80) @(negedge clk);
        check_eq("halt_no_tick", 8'(tick_seen - t0), 8'd0);
        bus_read(8'h21, v); check_eq("halt_sec", v, 8'h30);
        bus_write(1'b1, 8'h00);
        bus_write(1'b0, 8'h00);
        t0 = tick_seen;
        repeat (41) @(negedge clk);
        check_eq("resume_ticks", 8'(tick_seen - t0), 8'd10);
        bus_write(1'b0, 8'h01);
        bus_read(8'h21, v); check_eq("resume_sec", v, 8'h41);

        set_reg(8'h30, 8'hAA);
        bus_read(8'h30, v); check_eq("unmapped", v, 8'h00);
        set_reg(8'h00, 8'hFF);
        bus_read(8'h00, v); check_eq("ctrl_bits", v, 8'h01);

        set_reg(8'h21, 8'h7A);
        set_reg(8'h22, 8'h15);
        run_one_tick();
        bus_read(8'h21, v); check_eq("bad_bcd_sec", v, 8'h00);
        bus_read(8'h22, v); check_eq("bad_bcd_min", v, 8'h16);

        // Reset in the middle of a read drops ad_oe before the next clock edge.
        bus_write(1'b1, 8'h24);
        bus.ad_sel = 1'b0; bus.rd = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_rd_oe", {7'b0, bus.ad_oe}, 8'h01);
        #2 reset = 1'b1;
        #1 check_eq("rst_mid_rd_oe", {7'b0, bus.ad_oe}, 8'h00);
        bus.rd = 1'b0; bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(8'h24, v); check_eq("post_rst_date", v, 8'h01);
        bus_read(8'h00, v); check_eq("post_rst_ctrl", v, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
